// File: rtl/gecko_reg_scoreboard.sv
// gecko_reg_scoreboard: per-register outstanding-write counters, operand status and issue gating for gecko decode.
// Optional feature macro GECKO_SCOREBOARD_TOTAL_EN adds a registered pending_total output that drives drain completion.
module gecko_reg_scoreboard #(
  parameter int NUM_REGS      = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int COUNTER_WIDTH = 2,
  parameter int NUM_WB_PORTS  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             issue_valid,
  output logic                             issue_ready,
  input  logic [ADDR_WIDTH-1:0]            issue_rs1,
  input  logic [ADDR_WIDTH-1:0]            issue_rs2,
  input  logic [ADDR_WIDTH-1:0]            issue_rd,
  input  logic [2:0]                       issue_use,
  input  logic                             issue_bypass,
  input  logic                             issue_ex_res,
  input  logic [NUM_WB_PORTS-1:0]          wb_valid,
  input  logic [NUM_WB_PORTS*ADDR_WIDTH-1:0] wb_addr,
  output logic [1:0]                       rs1_status,
  output logic [1:0]                       rs2_status,
  output logic [1:0]                       rd_status,
  output logic [ADDR_WIDTH-1:0]            ex_saved,
  input  logic                             drain_req,
  output logic                             drain_done,
  output logic                             underflow_err
`ifdef GECKO_SCOREBOARD_TOTAL_EN
  ,
  output logic [ADDR_WIDTH+COUNTER_WIDTH-1:0] pending_total
`endif
);

  typedef enum logic [1:0] {
    ST_VALID   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } gecko_reg_status_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DW = $clog2(NUM_WB_PORTS + 1);
  localparam int EW = COUNTER_WIDTH + DW + 1;
  localparam int TW = ADDR_WIDTH + COUNTER_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = {COUNTER_WIDTH{1'b1}};

  logic [COUNTER_WIDTH-1:0] cnt_r      [NUM_REGS];
  logic [COUNTER_WIDTH-1:0] cnt_next_s [NUM_REGS];
  state_t                   state_r;
  logic [ADDR_WIDTH-1:0]    ex_saved_r;
  logic                     drain_done_r;
  logic                     underflow_r;
  logic                     uf_any_s;
  logic                     any_pending_s;
  logic                     drain_clear_s;
  logic                     accept_s;
  logic                     rs1_ok_s, rs2_ok_s, rd_ok_s;

  function automatic logic [1:0] status_f(input logic [ADDR_WIDTH-1:0] a,
                                          input logic [COUNTER_WIDTH-1:0] c);
    if (a == '0 || c == '0) begin
      return ST_VALID;
    end else if (c == CNT_MAX) begin
      return ST_FULL;
    end else begin
      return ST_PARTIAL;
    end
  endfunction

  assign rs1_status = status_f(issue_rs1, cnt_r[issue_rs1]);
  assign rs2_status = status_f(issue_rs2, cnt_r[issue_rs2]);
  assign rd_status  = status_f(issue_rd,  cnt_r[issue_rd]);

  // A source held in execute is forwardable only when the instruction allows bypass.
  assign rs1_ok_s = !issue_use[2] || (rs1_status == ST_VALID) ||
                    (issue_bypass && issue_rs1 == ex_saved_r && issue_rs1 != '0);
  assign rs2_ok_s = !issue_use[1] || (rs2_status == ST_VALID) ||
                    (issue_bypass && issue_rs2 == ex_saved_r && issue_rs2 != '0);
  assign rd_ok_s  = !issue_use[0] || (rd_status != ST_FULL) || (issue_rd == '0);

  assign issue_ready   = (state_r == RUN) && rs1_ok_s && rs2_ok_s && rd_ok_s;
  assign accept_s      = issue_valid && issue_ready;
  assign ex_saved      = ex_saved_r;
  assign drain_done    = drain_done_r;
  assign underflow_err = underflow_r;

  // Next-count per register: add the accepted issue, subtract all matching retires, clamp at zero.
  always_comb begin
    logic [EW-1:0] sum_v;
    logic [EW-1:0] dec_v;
    uf_any_s      = 1'b0;
    any_pending_s = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      sum_v = EW'(cnt_r[r]) +
              ((accept_s && issue_use[0] && issue_rd == ADDR_WIDTH'(r)) ? EW'(1) : EW'(0));
      dec_v = '0;
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
        dec_v = dec_v + ((wb_valid[p] && wb_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))
                         ? EW'(1) : EW'(0));
      end
      any_pending_s = any_pending_s | (cnt_r[r] != '0);
      if (r == 0) begin
        cnt_next_s[r] = '0;
      end else if (dec_v > sum_v) begin
        cnt_next_s[r] = '0;
        uf_any_s      = 1'b1;
      end else begin
        cnt_next_s[r] = COUNTER_WIDTH'(sum_v - dec_v);
      end
    end
  end

`ifdef GECKO_SCOREBOARD_TOTAL_EN
  logic [TW-1:0] total_r;
  logic [TW-1:0] total_next_s;

  // Sum of next counts so the registered total tracks the counter array exactly.
  always_comb begin
    total_next_s = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      total_next_s = total_next_s + TW'(cnt_next_s[r]);
    end
  end

  // Registered pending-write total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_r <= '0;
    end else begin
      total_r <= total_next_s;
    end
  end

  assign pending_total = total_r;
  assign drain_clear_s = (total_r == '0);
`else
  assign drain_clear_s = !any_pending_s;
`endif

  // Counter array state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= cnt_next_s[r];
      end
    end
  end

  // Drain FSM, execute-forwarding register and sticky underflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= RUN;
      ex_saved_r   <= '0;
      drain_done_r <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      underflow_r  <= underflow_r | uf_any_s;
      drain_done_r <= 1'b0;
      case (state_r)
        RUN: begin
          if (drain_req) begin
            state_r <= DRAIN;
          end
          if (accept_s && issue_use[0]) begin
            if (issue_ex_res) begin
              ex_saved_r <= issue_rd;
            end else if (issue_rd == ex_saved_r) begin
              ex_saved_r <= '0;
            end
          end
        end
        DRAIN: begin
          if (drain_clear_s) begin
            state_r      <= DONE;
            drain_done_r <= 1'b1;
          end
        end
        DONE: begin
          ex_saved_r <= '0;
          state_r    <= RUN;
        end
        default: state_r <= RUN;
      endcase
    end
  end

endmodule
